tx_stream_scheduler: RTL

- Sequences the output side of the HDMI path in the TX pixel-clock domain.
- Holds the timing generator in restart until the processed-pixel FIFO is prefilled, then issues FIFO reads in lockstep with active video.
- Detects FIFO underflow and substitutes black; recovers frame alignment by flushing and refilling the FIFO during vertical blanking, without stopping sync generation.
- Aligns sync, DE and pixel for the DVI encoder.

---
 rtl/tx_stream_scheduler.sv | 126 ++++++++++++
 1 files changed

// File: rtl/tx_stream_scheduler.sv
// Output-side scheduler for the HDMI TX path: FIFO prefill, lockstep reads, underflow recovery,
// and a one-cycle sync/DE/pixel pipeline towards the DVI encoder.
module tx_stream_scheduler #(
  parameter int unsigned LEVEL_W       = 11,
  parameter int unsigned PREFILL_LEVEL = 640,
  parameter int unsigned FLUSH_CYCLES  = 8,
  parameter logic [23:0] BLACK         = 24'h000000
) (
  input  logic               clk,
  input  logic               rstbtn_n,
  input  logic               en,
  input  logic               hblnk,
  input  logic               vblnk,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [LEVEL_W-1:0] fifo_level,
  input  logic               fifo_empty,
  input  logic [23:0]        fifo_dout,
  input  logic               fifo_valid,
  output logic               timing_restart,
  output logic               fifo_rd_en,
  output logic               fifo_flush,
  output logic [23:0]        pixel_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               de_out,
  output logic               running,
  input  logic               underflow_clr,
  output logic               underflow_sticky,
  output logic [15:0]        underflow_count,
  output logic [15:0]        frame_count
);

  localparam int unsigned FlushW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FlushW-1:0] FlushLast = FlushW'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StRun, StRecover, StFlush, StRefill} state_e;

  state_e            state_q, state_d;
  logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;
  logic              vsync_q, vblnk_q;

  logic active, vs_rise, vb_rise, level_ok, underflow_ev;

  assign active       = !hblnk && !vblnk;
  assign vs_rise      = vsync_in && !vsync_q;
  assign vb_rise      = vblnk && !vblnk_q;
  assign level_ok     = fifo_level >= LEVEL_W'(PREFILL_LEVEL);
  assign underflow_ev = (state_q == StRun) && active && fifo_empty;

  always_ff @(posedge clk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      state_q     <= StIdle;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      StIdle:    if (level_ok) state_d = StRun;
      StRun:     if (underflow_ev) state_d = StRecover;
      StRecover: begin
        if (vb_rise) begin
          state_d     = StFlush;
          flush_cnt_d = '0;
        end
      end
      StFlush: begin
        if (flush_cnt_q == FlushLast) state_d = StRefill;
        else flush_cnt_d = flush_cnt_q + 1'b1;
      end
      StRefill:  if (vs_rise && level_ok) state_d = StRun;
      default:   state_d = StIdle;
    endcase
    // Disable wins from any state and abandons a flush in progress.
    if (!en) begin
      state_d     = StIdle;
      flush_cnt_d = '0;
    end
  end

  always_comb begin
    timing_restart = (state_q == StIdle);
    running        = (state_q == StRun);
    fifo_flush     = (state_q == StFlush);
    fifo_rd_en     = (state_q == StRun) && active && !fifo_empty;
  end

  // Sync/DE delayed one cycle; pixel_out registers whatever the FIFO presents as valid.
  always_ff @(posedge clk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      vsync_q   <= 1'b0;
      vblnk_q   <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      de_out    <= 1'b0;
      pixel_out <= BLACK;
    end else begin
      vsync_q   <= vsync_in;
      vblnk_q   <= vblnk;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
      de_out    <= active && !timing_restart;
      pixel_out <= fifo_valid ? fifo_dout : BLACK;
    end
  end

  always_ff @(posedge clk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      underflow_sticky <= 1'b0;
      underflow_count  <= '0;
      frame_count      <= '0;
    end else begin
      if (underflow_ev) underflow_sticky <= 1'b1;
      else if (underflow_clr) underflow_sticky <= 1'b0;
      if (underflow_ev && (underflow_count != 16'hFFFF)) underflow_count <= underflow_count + 1'b1;
      if ((state_q == StRun) && vb_rise) frame_count <= frame_count + 1'b1;
    end
  end

endmodule
